// File: rtl/app_state_ctrl.sv
// Top-level screen sequencer: menu cursor, timed loading bar, app dispatch and return-to-menu handling.
// Buttons are synchronised and edge-detected here; app completion pulses arrive already in the clk domain.
module app_state_ctrl #(
    parameter int LOAD_STEP   = 1024,
    parameter int OVER_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       game_over,
    input  logic       mix_done,
    output logic [3:0] state,
    output logic [1:0] menu_sel,
    output logic [6:0] load_progress,
    output logic       app_reset
);

    // state | meaning
    // 0     | MENU       cursor moves, btnC launches LOADING
    // 1     | VOLUME     app; btnL back to MENU
    // 2     | POKEMON    app; game_over -> POKE_OVER, btnL -> MENU
    // 3     | POKE_OVER  timed screen; btnC/btnL or timeout -> MENU
    // 4     | BLUE_TEST  app; btnL back to MENU
    // 5     | POTION     app; mix_done or btnL -> MENU
    // 6     | LOADING    bar fills, then jumps to the latched target
    // 7-15  | illegal    recover to MENU with everything cleared

    localparam logic [3:0] S_MENU      = 4'd0;
    localparam logic [3:0] S_VOLUME    = 4'd1;
    localparam logic [3:0] S_POKEMON   = 4'd2;
    localparam logic [3:0] S_POKE_OVER = 4'd3;
    localparam logic [3:0] S_BLUE_TEST = 4'd4;
    localparam logic [3:0] S_POTION    = 4'd5;
    localparam logic [3:0] S_LOADING   = 4'd6;

    localparam int STEP_W = (LOAD_STEP > 1) ? $clog2(LOAD_STEP) : 1;
    localparam int OVER_W = (OVER_CYCLES > 1) ? $clog2(OVER_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LOAD_STEP - 1);
    localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(OVER_CYCLES - 1);
    localparam logic [6:0] PROG_LAST = 7'd95;
    localparam logic [6:0] PROG_FULL = 7'd96;

    // bit order {L, D, U, C}
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] rise;

    logic [3:0]        state_q, state_d;
    logic [1:0]        menu_sel_q, menu_sel_d;
    logic [3:0]        target_q, target_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [OVER_W-1:0] over_q, over_d;
    logic [6:0]        prog_q, prog_d;
    logic              app_reset_q, app_reset_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            state_q     <= S_MENU;
            menu_sel_q  <= '0;
            target_q    <= '0;
            step_q      <= '0;
            over_q      <= '0;
            prog_q      <= '0;
            app_reset_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            menu_sel_q  <= menu_sel_d;
            target_q    <= target_d;
            step_q      <= step_d;
            over_q      <= over_d;
            prog_q      <= prog_d;
            app_reset_q <= app_reset_d;
        end
    end

    always_comb begin
        sync1_d = {btnL, btnD, btnU, btnC};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;

        state_d    = state_q;
        menu_sel_d = menu_sel_q;
        target_d   = target_q;
        step_d     = step_q;
        over_d     = over_q;
        prog_d     = prog_q;

        case (state_q)
            S_MENU: begin
                if (rise[0]) begin
                    case (menu_sel_q)
                        2'd0:    target_d = S_VOLUME;
                        2'd1:    target_d = S_POKEMON;
                        2'd2:    target_d = S_POTION;
                        default: target_d = S_BLUE_TEST;
                    endcase
                    step_d  = STEP_LAST;
                    prog_d  = '0;
                    state_d = S_LOADING;
                end else if (rise[1] && !rise[2]) begin
                    menu_sel_d = menu_sel_q - 2'd1;
                end else if (rise[2] && !rise[1]) begin
                    menu_sel_d = menu_sel_q + 2'd1;
                end
            end
            S_LOADING: begin
                if (step_q == '0) begin
                    step_d = STEP_LAST;
                    if (prog_q == PROG_LAST) begin
                        prog_d  = PROG_FULL;
                        state_d = target_q;
                    end else begin
                        prog_d = prog_q + 7'd1;
                    end
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
            S_VOLUME, S_BLUE_TEST: begin
                if (rise[3]) state_d = S_MENU;
            end
            S_POKEMON: begin
                // game_over beats a simultaneous btnL so the over screen is never skipped
                if (game_over) begin
                    state_d = S_POKE_OVER;
                    over_d  = OVER_LAST;
                end else if (rise[3]) begin
                    state_d = S_MENU;
                end
            end
            S_POKE_OVER: begin
                if (rise[0] || rise[3] || over_q == '0) begin
                    state_d = S_MENU;
                end else begin
                    over_d = over_q - OVER_W'(1);
                end
            end
            S_POTION: begin
                if (mix_done || rise[3]) state_d = S_MENU;
            end
            default: begin
                state_d    = S_MENU;
                menu_sel_d = '0;
                target_d   = '0;
                step_d     = '0;
                over_d     = '0;
                prog_d     = '0;
            end
        endcase

        app_reset_d = (state_d != state_q) &&
                      (state_d == S_VOLUME || state_d == S_POKEMON ||
                       state_d == S_BLUE_TEST || state_d == S_POTION);
    end

    always_comb begin
        state         = state_q;
        menu_sel      = menu_sel_q;
        load_progress = prog_q;
        app_reset     = app_reset_q;
    end

endmodule

// File: tb/tb_app_state_ctrl.sv
// Self-checking bench for app_state_ctrl with short timers (LOAD_STEP=4, OVER_CYCLES=16).
module tb_app_state_ctrl;

    localparam int LS = 4;
    localparam int OC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnC = 1'b0, btnU = 1'b0, btnD = 1'b0, btnL = 1'b0;
    logic       game_over = 1'b0, mix_done = 1'b0;
    logic [3:0] state;
    logic [1:0] menu_sel;
    logic [6:0] load_progress;
    logic       app_reset;

    app_state_ctrl #(.LOAD_STEP(LS), .OVER_CYCLES(OC)) dut (
        .clk(clk), .rst_n(rst_n), .btnC(btnC), .btnU(btnU), .btnD(btnD), .btnL(btnL),
        .game_over(game_over), .mix_done(mix_done), .state(state), .menu_sel(menu_sel),
        .load_progress(load_progress), .app_reset(app_reset)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string name;
        int    st;
        int    sel;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       u;
        logic       d;
        logic [1:0] sel;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input int st, input int sel);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.sel  = sel;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check({e.name, "_state"}, 32'(state), e.st);
            check({e.name, "_sel"}, 32'(menu_sel), e.sel);
        end
    endtask

    // mask bits: 0 C, 1 U, 2 D, 3 L
    task automatic pulse_btn(input logic [3:0] m);
        @(negedge clk);
        btnC = m[0]; btnU = m[1]; btnD = m[2]; btnL = m[3];
        repeat (2) @(negedge clk);
        btnC = 1'b0; btnU = 1'b0; btnD = 1'b0; btnL = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic go_app(input string name, input int exp_st);
        int n;
        pulse_btn(4'b0001);
        check({name, "_loading"}, 32'(state), 6);
        n = 0;
        while (state == 4'd6 && n < 96 * LS + 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_state"}, 32'(state), exp_st);
        check({name, "_prog"}, 32'(load_progress), 96);
        check({name, "_app_reset_hi"}, 32'(app_reset), 1);
        @(posedge clk);
        #1;
        check({name, "_app_reset_lo"}, 32'(app_reset), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{u: 1'b0, d: 1'b1, sel: 2'd1};
        vecs[1] = '{u: 1'b0, d: 1'b1, sel: 2'd2};
        vecs[2] = '{u: 1'b0, d: 1'b1, sel: 2'd3};
        vecs[3] = '{u: 1'b0, d: 1'b1, sel: 2'd0};
        vecs[4] = '{u: 1'b1, d: 1'b0, sel: 2'd3};
        vecs[5] = '{u: 1'b1, d: 1'b1, sel: 2'd3};
        vecs[6] = '{u: 1'b1, d: 1'b0, sel: 2'd2};
        vecs[7] = '{u: 1'b0, d: 1'b1, sel: 2'd3};

        #2;
        check("rst_state", 32'(state), 0);
        check("rst_sel", 32'(menu_sel), 0);
        check("rst_prog", 32'(load_progress), 0);
        check("rst_app_reset", 32'(app_reset), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T2 cursor table
        for (int i = 0; i < 8; i++) begin
            sb_push($sformatf("cursor%0d", i), 0, int'(vecs[i].sel));
            pulse_btn({1'b0, vecs[i].d, vecs[i].u, 1'b0});
            sb_pop_check();
        end

        // bring cursor to POKEMON
        sb_push("to_pkmn_a", 0, 0);
        pulse_btn(4'b0100);
        sb_pop_check();
        sb_push("to_pkmn_b", 0, 1);
        pulse_btn(4'b0100);
        sb_pop_check();

        // T3 loading timing, btnL ignored while loading
        @(negedge clk);
        btnC = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t3_pre", 32'(state), 0);
        @(posedge clk);
        #1;
        check("t3_enter", 32'(state), 6);
        check("t3_prog0", 32'(load_progress), 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_prog_e3", 32'(load_progress), 0);
        @(posedge clk);
        #1;
        check("t3_prog_e4", 32'(load_progress), 1);
        for (int i = 0; i < 379; i++) begin
            @(posedge clk);
            #2;
            if (i == 1) btnC = 1'b0;
            if (i == 10) btnL = 1'b1;
            if (i == 20) btnL = 1'b0;
            if (i == 35) check("t3_mid", 32'(load_progress), 10);
        end
        check("t3_last_state", 32'(state), 6);
        check("t3_last_prog", 32'(load_progress), 95);
        check("t3_last_ar", 32'(app_reset), 0);
        @(posedge clk);
        #1;
        check("t3_done_state", 32'(state), 2);
        check("t3_done_prog", 32'(load_progress), 96);
        check("t3_done_ar", 32'(app_reset), 1);
        @(posedge clk);
        #1;
        check("t3_ar_lo", 32'(app_reset), 0);
        check("t3_hold_state", 32'(state), 2);

        // T4 over screen timeout
        @(negedge clk);
        game_over = 1'b1;
        @(posedge clk);
        #1;
        check("t4_over", 32'(state), 3);
        @(negedge clk);
        game_over = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("t4_before_timeout", 32'(state), 3);
        @(posedge clk);
        #1;
        check("t4_timeout", 32'(state), 0);
        check("t4_sel_kept", 32'(menu_sel), 1);

        // T4 repeat, btnC leaves the over screen early
        go_app("t4_pkmn", 2);
        @(negedge clk);
        game_over = 1'b1;
        @(posedge clk);
        #1;
        check("t4b_over", 32'(state), 3);
        @(negedge clk);
        game_over = 1'b0;
        repeat (7) @(negedge clk);
        btnC = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t4b_pre", 32'(state), 3);
        @(posedge clk);
        #1;
        check("t4b_btnc", 32'(state), 0);
        @(negedge clk);
        btnC = 1'b0;
        repeat (3) @(negedge clk);

        // T5 game_over beats btnL
        go_app("t5_pkmn", 2);
        @(negedge clk);
        btnL = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        game_over = 1'b1;
        @(posedge clk);
        #1;
        check("t5_gameover_wins", 32'(state), 3);
        @(negedge clk);
        game_over = 1'b0;
        btnL = 1'b0;
        @(posedge clk);
        #1;
        check("t5_still_over", 32'(state), 3);
        sb_push("t5_over_back", 0, 1);
        pulse_btn(4'b1000);
        sb_pop_check();
        sb_push("t5_to_vol", 0, 0);
        pulse_btn(4'b0010);
        sb_pop_check();
        go_app("t5_vol", 1);
        sb_push("t5_vol_back", 0, 0);
        pulse_btn(4'b1000);
        sb_pop_check();

        // T6 held button, stray pulses in MENU
        @(negedge clk);
        btnD = 1'b1;
        repeat (1000) @(negedge clk);
        btnD = 1'b0;
        check("t6_held", 32'(menu_sel), 1);
        repeat (3) @(negedge clk);
        mix_done = 1'b1;
        @(negedge clk);
        mix_done = 1'b0;
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        @(negedge clk);
        check("t6_stray_state", 32'(state), 0);
        check("t6_stray_sel", 32'(menu_sel), 1);
        sb_push("t6_to_potion", 0, 2);
        pulse_btn(4'b0100);
        sb_pop_check();
        go_app("t6_potion", 5);
        @(negedge clk);
        mix_done = 1'b1;
        @(posedge clk);
        #1;
        check("t6_mix_done", 32'(state), 0);
        @(negedge clk);
        mix_done = 1'b0;
        sb_push("t6_to_blue", 0, 3);
        pulse_btn(4'b0100);
        sb_pop_check();
        go_app("t6_blue", 4);
        sb_push("t6_blue_back", 0, 3);
        pulse_btn(4'b1000);
        sb_pop_check();

        // T1 asynchronous reset mid-LOADING
        pulse_btn(4'b0001);
        repeat (50) @(posedge clk);
        #2;
        check("t1_in_loading", 32'(state), 6);
        rst_n = 1'b0;
        #1;
        check("t1_state", 32'(state), 0);
        check("t1_prog", 32'(load_progress), 0);
        check("t1_sel", 32'(menu_sel), 0);
        check("t1_ar", 32'(app_reset), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("t1_release_ar%0d", i), 32'(app_reset), 0);
        end
        check("t1_release_state", 32'(state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
